// File: rtl/bus_responder_if.sv
// bus_responder_if: asynchronous-style 16-bit slave bus bundle.
// master drives A/UDS/LDS/AS/RW/D_IN; slave returns D_OUT/D_OE/DTACK/BERR.
interface bus_responder_if;
  logic [31:1] A;
  logic        UDS;
  logic        LDS;
  logic        AS;
  logic        RW;
  logic [15:0] D_IN;
  logic [15:0] D_OUT;
  logic        D_OE;
  logic        DTACK;
  logic        BERR;

  modport master (
    output A, UDS, LDS, AS, RW, D_IN,
    input  D_OUT, D_OE, DTACK, BERR
  );

  modport slave (
    input  A, UDS, LDS, AS, RW, D_IN,
    output D_OUT, D_OE, DTACK, BERR
  );
endinterface

// File: rtl/bus_responder.sv
// bus_responder: word-wide memory slave with wait states and DTACK.
// Ports: CLK, RESET (sync, active-high), bus (bus_responder_if.slave).
// Macro BUS_RESPONDER_BERR_EN: misses raise BERR instead of being ignored.
module bus_responder #(
  parameter logic [23:0] BASE_ADDR   = 24'h000000,
  parameter int          ADDR_BITS   = 8,
  parameter int          WAIT_STATES = 2
) (
  input logic            CLK,
  input logic            RESET,
  bus_responder_if.slave bus
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] ACK    = 3'd3;
  localparam logic [2:0] IGNORE = 3'd5;
`ifdef BUS_RESPONDER_BERR_EN
  localparam logic [2:0] FAULT  = 3'd4;
  localparam logic [2:0] MISS   = FAULT;
`else
  localparam logic [2:0] MISS   = IGNORE;
`endif

  localparam int          DEPTH  = 1 << ADDR_BITS;
  localparam logic [22:0] BASE_W = BASE_ADDR[23:1];
  localparam logic [3:0]  WS     = 4'(WAIT_STATES);

  logic [2:0]  state;
  logic [2:0]  nxt;
  logic [3:0]  cnt;
  logic [22:0] a_q;
  logic        rw_q;
  logic        uds_q;
  logic        lds_q;
  logic [15:0] d_q;
  logic [15:0] mem [DEPTH];

  logic [22:0]          off;
  logic                 hit;
  logic [ADDR_BITS-1:0] idx;
  logic [15:0]          lane;
  logic                 enter_ack;

  logic        dtack;
  logic        d_oe;
  logic [15:0] d_out;
  logic        unused_hi;

  assign unused_hi = ^bus.A[31:24];

  // modular subtract: addresses below the base wrap high and miss
  assign off  = a_q - BASE_W;
  assign hit  = (off >> ADDR_BITS) == 23'd0;
  assign idx  = off[ADDR_BITS-1:0];
  assign lane = {{8{uds_q}}, {8{lds_q}}};

  assign enter_ack = (nxt == ACK) && (state != ACK);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:
        if (bus.AS) nxt = DECODE;
      DECODE:
        if (!hit)                  nxt = MISS;
        else if (WS == 4'd0)       nxt = ACK;
        else                       nxt = WAIT;
      WAIT:
        if (!bus.AS)               nxt = IDLE;
        else if (cnt == 4'd1)      nxt = ACK;
      ACK:
        if (!bus.AS) nxt = IDLE;
`ifdef BUS_RESPONDER_BERR_EN
      FAULT:
        if (!bus.AS) nxt = IDLE;
`endif
      IGNORE:
        if (!bus.AS) nxt = IDLE;
      default:
        nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      cnt   <= 4'd0;
      dtack <= 1'b0;
      d_oe  <= 1'b0;
      d_out <= 16'h0000;
    end else begin
      state <= nxt;
      if (state == DECODE)
        cnt <= WS;
      else if (state == WAIT && cnt != 4'd0)
        cnt <= cnt - 4'd1;
      dtack <= nxt == ACK;
      d_oe  <= (nxt == ACK) && rw_q;
      if (enter_ack && rw_q)
        d_out <= mem[idx] & lane;
      else if (nxt != ACK)
        d_out <= 16'h0000;
    end
  end

  // request capture; only meaningful while a transfer is in flight
  always_ff @(posedge CLK) begin
    if (state == IDLE && bus.AS) begin
      a_q   <= bus.A[23:1];
      rw_q  <= bus.RW;
      uds_q <= bus.UDS;
      lds_q <= bus.LDS;
      d_q   <= bus.D_IN;
    end
  end

  // storage is deliberately outside reset
  always_ff @(posedge CLK) begin
    if (!RESET && enter_ack && !rw_q) begin
      if (uds_q) mem[idx][15:8] <= d_q[15:8];
      if (lds_q) mem[idx][7:0]  <= d_q[7:0];
    end
  end

`ifdef BUS_RESPONDER_BERR_EN
  logic berr;

  always_ff @(posedge CLK) begin
    if (RESET) berr <= 1'b0;
    else       berr <= nxt == FAULT;
  end

  assign bus.BERR = berr;
`else
  assign bus.BERR = 1'b0;
`endif

  assign bus.DTACK = dtack;
  assign bus.D_OE  = d_oe;
  assign bus.D_OUT = d_out;
endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 Parameter BASE_ADDR, default 24'h000000, word-aligned byte base address of the decoded window (compared against {A[23:1],1'b0}).
REQ-002 Parameter ADDR_BITS, default 8, log2 of window size in 16-bit words; storage is 2**ADDR_BITS words.
REQ-003 Parameter WAIT_STATES, default 2, range 0-15, extra CLK cycles inserted before DTACK.
REQ-004 Port CLK  in  1  clock; all state changes on rising edge.
REQ-005 Port RESET  in  1  synchronous, active-high reset.
REQ-006 Port A  in  31 (31:1)  word address from bus master; bits 31:24 ignored.
REQ-007 Ports UDS, LDS  in  1 each  active-high byte strobes, D[15:8] and D[7:0] respectively.
REQ-008 Port AS  in  1  active-high address strobe; the transfer is valid while high.
REQ-009 Port RW  in  1  1 = read, 0 = write.
REQ-010 Port D_IN  in  16  write data from master.
REQ-011 Port D_OUT  out  16  read data to master.
REQ-012 Port D_OE  out  1  high while D_OUT is driven onto the bus.
REQ-013 Port DTACK  out  1  active-high transfer acknowledge.
REQ-014 Port BERR  out  1  active-high bus error; present only with BUS_RESPONDER_BERR_EN, otherwise tied 0.

Function
REQ-015 States IDLE, DECODE, WAIT, ACK, FAULT, IGNORE; all outputs are registered or decoded from the registered state.
REQ-016 IDLE: at an edge sampling AS=1, latch A, RW, UDS, LDS and D_IN, then go to DECODE.
REQ-017 DECODE: hit = (A[23:1] word index − BASE_ADDR/2) < 2**ADDR_BITS; on hit go to ACK if WAIT_STATES=0, else go to WAIT with counter=WAIT_STATES.
REQ-018 WAIT: decrement the counter each cycle; when counter=1, go to ACK; AS=0 in any WAIT cycle aborts to IDLE with no DTACK and no write.
REQ-019 Latency: AS sampled high at edge k, DTACK high from edge k+1+WAIT_STATES.
REQ-020 Write: on the edge entering ACK, write D_IN[15:8] if UDS and D_IN[7:0] if LDS; no strobe means no write, but DTACK is still issued.
REQ-021 Read: in ACK, D_OE=1; D_OUT carries the stored word with unstrobed byte lanes forced to 8'h00.
REQ-022 ACK: DTACK=1, held until AS sampled 0, then go to IDLE; DTACK and D_OE are 0 after that edge.
REQ-023 Miss: go to FAULT with BUS_RESPONDER_BERR_EN, otherwise to IGNORE.
REQ-024 FAULT: BERR=1, DTACK=0, and the state is held until AS=0, then IDLE; IGNORE holds with all outputs 0 until AS=0.
REQ-025 Each AS assertion yields at most one write and one DTACK pulse.
REQ-026 Back-to-back transfers need AS low for at least one sampled edge between them.

Reset
REQ-027 RESET at an edge forces IDLE, and DTACK=0, BERR=0, D_OE=0, D_OUT=16'h0000 and counter=0, overriding any in-flight transfer; no write occurs on that edge.
REQ-028 Storage contents are not altered by RESET.

Configuration
REQ-029 With macro BUS_RESPONDER_BERR_EN defined, misses assert BERR via FAULT; without it, the FAULT logic is not built, BERR is constant 0, and misses go silently to IGNORE (the master times out).

Verification
REQ-030 WAIT_STATES=2, write 16'hA55A to BASE+4 with UDS=LDS=1 -> DTACK rises 3 edges after AS sampled; a subsequent read returns 16'hA55A with D_OE=1.
REQ-031 Write 16'h1234 to word 0, then a LDS-only write of 16'hFF99 -> a full read returns 16'h1299; a UDS-only read returns 16'h1200.
REQ-032 AS dropped after 1 WAIT cycle on a write of 16'hBEEF -> no DTACK, and a later read shows the old value.
REQ-033 Access to BASE+2**(ADDR_BITS+1) -> with macro, BERR high until AS low and DTACK never high; without macro, all outputs stay 0.
REQ-034 RESET asserted while in ACK -> next edge DTACK=0 and D_OE=0 with state IDLE; stored data unchanged on readback.
REQ-035 WAIT_STATES=0 -> DTACK high 1 edge after AS sampled; holding AS for 5 cycles gives a single DTACK pulse lasting until AS low.
